mdu_mul_sequencer: RTL and testbench

Sequencer that sits between the execute stage of the 5-stage RV32I+M pipeline and the shared iterative multiplier. It accepts a multiply request from E, latches operands and opcode, issues a one-cycle start to the multiplier, and holds the front of the pipeline until the product is returned. It also absorbs E-stage flushes while a multiply is in flight and bounds multiplier latency with a watchdog.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu_timeout_cnt.sv | 42 ++++
 rtl/mdu_mul_sequencer.sv | 156 +++++++++++++++
 tb/tb_mdu_mul_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit: opcode and
// sequencer state encodings plus the default watchdog limit.
package mdu_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE,
        S_DRAIN
    } seq_state_e;

    // Default multiplier watchdog limit and the counter width that covers it.
    localparam int unsigned MDU_TIMEOUT = 40;
    localparam int unsigned MDU_CNT_W   = 6;

endpackage

// File: rtl/mdu_timeout_cnt.sv
// Saturating watchdog counter: clear has priority over enable, and expired
// stays high once the count reaches TIMEOUT.
module mdu_timeout_cnt
    import mdu_pkg::*;
#(
    parameter int unsigned CNT_W   = MDU_CNT_W,
    parameter int unsigned TIMEOUT = MDU_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = (cnt_q >= LIMIT);

    // Next count: clear, else increment until the limit is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mdu_mul_sequencer.sv
// Sequencer between the execute stage and the shared iterative multiplier:
// latches the request, pulses start, stalls the front end until the product
// returns, absorbs E-stage flushes and bounds latency with a watchdog.
module mdu_mul_sequencer
    import mdu_pkg::*;
#(
    parameter int unsigned TIMEOUT = MDU_TIMEOUT,
    parameter int unsigned CNT_W   = MDU_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mul_req,
    input  logic [1:0]  mul_opcode,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic        flush_e,
    output logic        mult_start,
    output logic [1:0]  mult_op,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    input  logic        mult_done,
    input  logic [31:0] mult_result,
    output logic        stall,
    output logic        result_valid,
    output logic [31:0] result,
    output logic        timeout_err
);

    seq_state_e  state_q, state_d;
    logic        mult_start_q, mult_start_d;
    mul_op_e     op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] result_q, result_d;
    logic        result_valid_q, result_valid_d;
    logic        timeout_err_q, timeout_err_d;

    logic        wd_clr;
    logic        wd_en;
    logic        wd_expired;

    mdu_timeout_cnt #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    assign mult_start   = mult_start_q;
    assign mult_op      = op_q;
    assign mult_a       = a_q;
    assign mult_b       = b_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign timeout_err  = timeout_err_q;

    // Front-end hold: a request being accepted, any in-flight multiply, or a
    // new request waiting behind a drain.
    assign stall = ((state_q == S_IDLE) && mul_req && !flush_e)
                 || (state_q == S_BUSY)
                 || ((state_q == S_DRAIN) && mul_req);

    // Next-state and registered-output logic. The watchdog counts every BUSY
    // cycle from the start cycle, so it reads TIMEOUT at T+1+TIMEOUT.
    always_comb begin
        state_d        = state_q;
        mult_start_d   = 1'b0;
        op_d           = op_q;
        a_d            = a_q;
        b_d            = b_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        timeout_err_d  = 1'b0;
        wd_clr         = 1'b0;
        wd_en          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mul_req && !flush_e) begin
                    op_d         = mul_op_e'(mul_opcode);
                    a_d          = operand1;
                    b_d          = operand2;
                    mult_start_d = 1'b1;
                    wd_clr       = 1'b1;
                    state_d      = S_BUSY;
                end
            end
            S_BUSY: begin
                wd_en = 1'b1;
                if (mult_start_q) begin
                    // Start cycle: any mult_done here is stale and ignored.
                    if (flush_e) begin
                        wd_clr  = 1'b1;
                        state_d = S_DRAIN;
                    end
                end else if (flush_e) begin
                    if (mult_done) begin
                        state_d = S_IDLE;
                    end else begin
                        wd_clr  = 1'b1;
                        state_d = S_DRAIN;
                    end
                end else if (mult_done) begin
                    result_d       = mult_result;
                    result_valid_d = 1'b1;
                    state_d        = S_DONE;
                end else if (wd_expired) begin
                    result_d       = '0;
                    result_valid_d = 1'b1;
                    timeout_err_d  = 1'b1;
                    state_d        = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                wd_en = 1'b1;
                if (mult_done || wd_expired) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            mult_start_q   <= 1'b0;
            op_q           <= MUL;
            a_q            <= '0;
            b_q            <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            mult_start_q   <= mult_start_d;
            op_q           <= op_d;
            a_q            <= a_d;
            b_q            <= b_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_mdu_mul_sequencer.sv
// Self-checking bench for mdu_mul_sequencer with a behavioural multiplier of
// programmable latency and an arithmetic reference for the four opcodes.
module tb_mdu_mul_sequencer;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mul_req;
    logic [1:0]  mul_opcode;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        flush_e;
    logic        mult_start;
    logic [1:0]  mult_op;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic        mult_done;
    logic [31:0] mult_result;
    logic        stall;
    logic        result_valid;
    logic [31:0] result;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;

    // Multiplier model controls
    int          m_lat   = 32;
    bit          m_never = 1'b0;
    bit          m_act   = 1'b0;
    int          m_rem   = 0;
    logic [31:0] m_prod  = '0;

    mdu_mul_sequencer #(
        .TIMEOUT (MDU_TIMEOUT),
        .CNT_W   (MDU_CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mul_req      (mul_req),
        .mul_opcode   (mul_opcode),
        .operand1     (operand1),
        .operand2     (operand2),
        .flush_e      (flush_e),
        .mult_start   (mult_start),
        .mult_op      (mult_op),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_done    (mult_done),
        .mult_result  (mult_result),
        .stall        (stall),
        .result_valid (result_valid),
        .result       (result),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] sx, sy, zx, zy, p;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        zx = {32'd0, x};
        zy = {32'd0, y};
        case (op)
            2'b00:   begin p = zx * zy; return p[31:0];  end
            2'b01:   begin p = sx * sy; return p[63:32]; end
            2'b10:   begin p = sx * zy; return p[63:32]; end
            default: begin p = zx * zy; return p[63:32]; end
        endcase
    endfunction

    // Iterative multiplier stand-in: mult_done pulses m_lat cycles after the
    // start cycle; result lines carry noise whenever done is low.
    always @(posedge clk) begin
        mult_done   <= 1'b0;
        mult_result <= $urandom();
        if (mult_start === 1'b1 && !m_never) begin
            m_prod <= ref_mul(mult_op, mult_a, mult_b);
            if (m_lat == 1) begin
                mult_done   <= 1'b1;
                mult_result <= ref_mul(mult_op, mult_a, mult_b);
                m_act       <= 1'b0;
            end else begin
                m_rem <= m_lat - 1;
                m_act <= 1'b1;
            end
        end else if (m_act) begin
            if (m_rem == 1) begin
                mult_done   <= 1'b1;
                mult_result <= m_prod;
                m_act       <= 1'b0;
            end else begin
                m_rem <= m_rem - 1;
            end
        end
    end

    // Watch from the current (already sampled) cycle, index 0, until result_valid.
    task automatic observe(input logic [31:0] ea, input logic [31:0] eb, input logic [1:0] eop,
                           output int start_c, output int valid_c, output int stalls, output int starts,
                           output logic [31:0] res, output logic terr, output bit stable, output bit ok);
        int c;
        c = 0; start_c = -1; valid_c = -1; stalls = 0; starts = 0;
        stable = 1'b1; ok = 1'b0; res = '0; terr = 1'b0;
        while (c < 200) begin
            if (stall === 1'b1) stalls++;
            if (mult_start === 1'b1) begin
                starts++;
                if (start_c < 0) start_c = c;
            end
            if (start_c >= 0 && (mult_a !== ea || mult_b !== eb || mult_op !== eop)) stable = 1'b0;
            if (result_valid === 1'b1) begin
                valid_c = c; res = result; terr = timeout_err; ok = 1'b1;
                break;
            end
            c++;
            @(negedge clk); #1;
        end
    endtask

    task automatic run_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int lat,
                           output int start_c, output int valid_c, output int stalls, output int starts,
                           output logic [31:0] res, output logic terr, output bit stable, output bit ok);
        @(negedge clk);
        mul_req = 1'b1; flush_e = 1'b0;
        mul_opcode = op; operand1 = a; operand2 = b;
        m_lat = lat;
        #1;
        observe(a, b, op, start_c, valid_c, stalls, starts, res, terr, stable, ok);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            mul_req = 1'b0; flush_e = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; mul_req = 1'b0; flush_e = 1'b0;
        mul_opcode = 2'b00; operand1 = '0; operand2 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (mult_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", mult_start); end
        checks++; if (mult_op !== 2'b00) begin failures++; $display("FAIL reset_op got=%b exp=00", mult_op); end
        checks++; if (mult_a !== 32'd0) begin failures++; $display("FAIL reset_a got=%h exp=0", mult_a); end
        checks++; if (mult_b !== 32'd0) begin failures++; $display("FAIL reset_b got=%h exp=0", mult_b); end
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_terr got=%b exp=0", timeout_err); end
    endtask

    task automatic test_basic_mul;
        int sc, vc, st, sn; logic [31:0] r; logic te; bit sb, ok;
        run_mul(2'b00, 32'd7, 32'hFFFF_FFFD, 32, sc, vc, st, sn, r, te, sb, ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_bound no result_valid within 200 cycles"); end
        checks++; if (sc !== 1) begin failures++; $display("FAIL basic_start_cycle got=%0d exp=1", sc); end
        checks++; if (sn !== 1) begin failures++; $display("FAIL basic_start_pulses got=%0d exp=1", sn); end
        checks++; if (vc !== 34) begin failures++; $display("FAIL basic_valid_cycle got=%0d exp=34", vc); end
        checks++; if (r !== 32'hFFFF_FFEB) begin failures++; $display("FAIL basic_result got=%h exp=ffffffeb", r); end
        checks++; if (st !== 34) begin failures++; $display("FAIL basic_stalls got=%0d exp=34", st); end
        checks++; if (te !== 1'b0) begin failures++; $display("FAIL basic_terr got=%b exp=0", te); end
        checks++; if (!sb) begin failures++; $display("FAIL basic_operand_hold latched operands changed"); end
        idle(2);
    endtask

    task automatic test_back_to_back;
        int sc, vc, st, sn; logic [31:0] r; logic te; bit sb, ok;
        run_mul(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, sc, vc, st, sn, r, te, sb, ok);
        checks++; if (!ok || r !== 32'hFFFF_FFFE) begin failures++; $display("FAIL b2b_mulhu got=%h exp=fffffffe ok=%0d", r, ok); end
        // Second request is driven in the cycle right after DONE.
        run_mul(2'b01, 32'h8000_0000, 32'd2, 32, sc, vc, st, sn, r, te, sb, ok);
        checks++; if (!ok || r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL b2b_mulh got=%h exp=ffffffff ok=%0d", r, ok); end
        checks++; if (sc !== 1) begin failures++; $display("FAIL b2b_start_cycle got=%0d exp=1", sc); end
        checks++; if (vc !== 34 || st !== 34) begin failures++; $display("FAIL b2b_timing got valid=%0d stalls=%0d exp=34/34", vc, st); end
        idle(1);
    endtask

    task automatic test_latency_bounds;
        int sc, vc, st, sn; logic [31:0] r; logic te; bit sb, ok;
        run_mul(2'b00, 32'h1234_5678, 32'd3, 1, sc, vc, st, sn, r, te, sb, ok);
        checks++; if (!ok || vc !== 3 || st !== 3) begin failures++; $display("FAIL lat1_timing got valid=%0d stalls=%0d exp=3/3", vc, st); end
        checks++; if (r !== ref_mul(2'b00, 32'h1234_5678, 32'd3)) begin failures++; $display("FAIL lat1_result got=%h exp=%h", r, ref_mul(2'b00, 32'h1234_5678, 32'd3)); end
        idle(1);
        run_mul(2'b10, 32'hFFFF_FFF0, 32'h0000_0100, MDU_TIMEOUT, sc, vc, st, sn, r, te, sb, ok);
        checks++; if (!ok || vc !== MDU_TIMEOUT + 2) begin failures++; $display("FAIL latmax_valid_cycle got=%0d exp=%0d", vc, MDU_TIMEOUT + 2); end
        checks++; if (te !== 1'b0) begin failures++; $display("FAIL latmax_terr got=%b exp=0", te); end
        checks++; if (r !== ref_mul(2'b10, 32'hFFFF_FFF0, 32'h0000_0100)) begin failures++; $display("FAIL latmax_result got=%h exp=%h", r, ref_mul(2'b10, 32'hFFFF_FFF0, 32'h0000_0100)); end
        idle(1);
        run_mul(2'b00, 32'd9, 32'd9, MDU_TIMEOUT + 1, sc, vc, st, sn, r, te, sb, ok);
        checks++; if (!ok || vc !== MDU_TIMEOUT + 2 || te !== 1'b1 || r !== 32'd0) begin
            failures++; $display("FAIL latover_timeout got valid=%0d terr=%b result=%h exp=%0d/1/0", vc, te, r, MDU_TIMEOUT + 2);
        end
        idle(2);
    endtask

    task automatic test_timeout;
        int sc, vc, st, sn; logic [31:0] r; logic te; bit sb, ok;
        m_never = 1'b1;
        run_mul(2'b00, 32'd11, 32'd13, 32, sc, vc, st, sn, r, te, sb, ok);
        checks++; if (!ok || vc !== MDU_TIMEOUT + 2) begin failures++; $display("FAIL timeout_cycle got=%0d exp=%0d", vc, MDU_TIMEOUT + 2); end
        checks++; if (te !== 1'b1) begin failures++; $display("FAIL timeout_terr got=%b exp=1", te); end
        checks++; if (r !== 32'd0) begin failures++; $display("FAIL timeout_result got=%h exp=0", r); end
        checks++; if (st !== MDU_TIMEOUT + 2) begin failures++; $display("FAIL timeout_stalls got=%0d exp=%0d", st, MDU_TIMEOUT + 2); end
        @(negedge clk); mul_req = 1'b0; #1;
        checks++; if (result_valid !== 1'b0 || timeout_err !== 1'b0 || stall !== 1'b0) begin
            failures++; $display("FAIL timeout_after got valid=%b terr=%b stall=%b exp=0/0/0", result_valid, timeout_err, stall);
        end
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL timeout_hold got=%h exp=0", result); end
        m_never = 1'b0;
        idle(1);
    endtask

    task automatic test_flush_drain;
        int sc, vc, st, sn; logic [31:0] r; logic te; bit sb, ok;
        bit early_valid;
        @(negedge clk);
        mul_req = 1'b1; flush_e = 1'b0; mul_opcode = 2'b01;
        operand1 = 32'h8000_0000; operand2 = 32'h7FFF_FFFF; m_lat = 32;
        repeat (8) @(negedge clk);                    // cycles 1..8
        @(negedge clk); mul_req = 1'b0; flush_e = 1'b1; #1;   // cycle 9
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL drain_stall_busy got=%b exp=1", stall); end
        @(negedge clk); flush_e = 1'b0; #1;           // cycle 10: DRAIN
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL drain_stall_drop got=%b exp=0", stall); end
        checks++; if (mult_a !== 32'h8000_0000 || mult_b !== 32'h7FFF_FFFF) begin
            failures++; $display("FAIL drain_operand_hold got a=%h b=%h exp=80000000/7fffffff", mult_a, mult_b);
        end
        early_valid = (result_valid === 1'b1);
        @(negedge clk); #1;                           // cycle 11
        early_valid = early_valid || (result_valid === 1'b1);
        checks++; if (early_valid) begin failures++; $display("FAIL drain_no_valid got result_valid=1 exp=0"); end
        @(negedge clk);                               // cycle 12: new request waits
        mul_req = 1'b1; mul_opcode = 2'b00; operand1 = 32'h0000_1234; operand2 = 32'h0000_0010;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL drain_new_stall got=%b exp=1", stall); end
        observe(32'h0000_1234, 32'h0000_0010, 2'b00, sc, vc, st, sn, r, te, sb, ok);
        checks++; if (!ok || sc !== 23) begin failures++; $display("FAIL drain_new_start got=%0d exp=23", sc); end
        checks++; if (vc !== 56 || st !== 56) begin failures++; $display("FAIL drain_new_timing got valid=%0d stalls=%0d exp=56/56", vc, st); end
        checks++; if (r !== 32'h0001_2340) begin failures++; $display("FAIL drain_new_result got=%h exp=00012340", r); end
        idle(1);
    endtask

    task automatic test_flush_with_done;
        int sc, vc, st, sn; logic [31:0] r; logic te; bit sb, ok;
        @(negedge clk);
        mul_req = 1'b1; flush_e = 1'b0; mul_opcode = 2'b00;
        operand1 = 32'h10; operand2 = 32'h10; m_lat = 10;
        repeat (10) @(negedge clk);                   // cycles 1..10
        @(negedge clk); mul_req = 1'b0; flush_e = 1'b1;       // cycle 11: done and flush
        @(negedge clk);                               // cycle 12
        flush_e = 1'b0; mul_req = 1'b1; mul_opcode = 2'b10;
        operand1 = 32'hFFFF_FFFF; operand2 = 32'd3; m_lat = 32;
        #1;
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL fd_no_valid got=%b exp=0", result_valid); end
        checks++; if (result !== 32'h0001_2340) begin failures++; $display("FAIL fd_result_discard got=%h exp=00012340", result); end
        observe(32'hFFFF_FFFF, 32'd3, 2'b10, sc, vc, st, sn, r, te, sb, ok);
        checks++; if (!ok || sc !== 1) begin failures++; $display("FAIL fd_idle_next got start=%0d exp=1", sc); end
        checks++; if (r !== 32'hFFFF_FFFF || vc !== 34) begin failures++; $display("FAIL fd_next_result got=%h valid=%0d exp=ffffffff/34", r, vc); end
        idle(1);
    endtask

    task automatic test_random;
        int sc, vc, st, sn; logic [31:0] r; logic te; bit sb, ok;
        int lat; logic [1:0] op; logic [31:0] a, b, exp_r;
        for (int i = 0; i < 10; i++) begin
            lat = $urandom_range(1, 38);
            op  = 2'($urandom_range(0, 3));
            a   = (i % 4 == 3) ? 32'h8000_0000 : $urandom();
            b   = $urandom();
            exp_r = ref_mul(op, a, b);
            run_mul(op, a, b, lat, sc, vc, st, sn, r, te, sb, ok);
            checks++; if (!ok || r !== exp_r) begin failures++; $display("FAIL rand%0d_result op=%0d got=%h exp=%h", i, op, r, exp_r); end
            checks++; if (vc !== lat + 2 || st !== lat + 2) begin failures++; $display("FAIL rand%0d_timing got valid=%0d stalls=%0d exp=%0d", i, vc, st, lat + 2); end
            checks++; if (sc !== 1 || sn !== 1) begin failures++; $display("FAIL rand%0d_start got cycle=%0d pulses=%0d exp=1/1", i, sc, sn); end
            checks++; if (te !== 1'b0 || !sb) begin failures++; $display("FAIL rand%0d_terr_hold got terr=%b stable=%0d exp=0/1", i, te, sb); end
            idle($urandom_range(0, 2));
        end
        idle(1);
    endtask

    task automatic test_reset_midop;
        bit bad;
        @(negedge clk);
        mul_req = 1'b1; flush_e = 1'b0; mul_opcode = 2'b00;
        operand1 = 32'd5; operand2 = 32'd6; m_lat = 32;
        repeat (4) @(negedge clk);                    // cycles 1..4
        @(negedge clk); rst = 1'b1; mul_req = 1'b0;   // cycle 5
        @(negedge clk); rst = 1'b0; #1;               // cycle 6
        checks++; if (stall !== 1'b0 || mult_start !== 1'b0 || result_valid !== 1'b0 || timeout_err !== 1'b0) begin
            failures++; $display("FAIL rstmid_ctrl got stall=%b start=%b valid=%b terr=%b exp=0", stall, mult_start, result_valid, timeout_err);
        end
        checks++; if (mult_a !== 32'd0 || mult_b !== 32'd0 || mult_op !== 2'b00 || result !== 32'd0) begin
            failures++; $display("FAIL rstmid_data got a=%h b=%h op=%b res=%h exp=0", mult_a, mult_b, mult_op, result);
        end
        bad = 1'b0;
        for (int c = 7; c <= 40; c++) begin           // stray done at cycle 33
            @(negedge clk); #1;
            if (stall !== 1'b0 || result_valid !== 1'b0 || mult_start !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL rstmid_stray_done got activity after reset exp=none"); end
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL rstmid_result_hold got=%h exp=0", result); end
    endtask

    initial begin
        test_reset;
        test_basic_mul;
        test_back_to_back;
        test_latency_bounds;
        test_timeout;
        test_flush_drain;
        test_flush_with_done;
        test_random;
        test_reset_midop;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
